// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared constants, FSM state type and score clamp helper
//
// GLYPH_SIZE : words per glyph in the shared 10-glyph digit ROM
// ROM_AW     : digit ROM address width
// sched_state_t : scheduler FSM states
// score_clamp_max(digits) : largest score displayable in <digits> decimal digits
package score_pkg;

   localparam int GLYPH_SIZE = 400;
   localparam int ROM_AW     = 12;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      CONVERT     = 2'd1,
      WAIT_COMMIT = 2'd2
   } sched_state_t;

   // 10^digits - 1, evaluated at elaboration for the clamp comparison.
   function automatic logic [63:0] score_clamp_max(input int digits);
      logic [63:0] v;
      v = 64'd1;
      for (int i = 0; i < digits; i++) begin
         v = v * 64'd10;
      end
      return v - 64'd1;
   endfunction

endpackage

// File: rtl/bcd_converter.sv
// rtl/bcd_converter.sv - sequential double-dabble binary to BCD converter
//
// i_clk  : clock
// i_rst  : synchronous active-high reset
// start  : one-cycle strobe, captures bin and restarts the conversion
// bin    : binary input, must be below 10^DIGITS
// done   : high in the cycle whose clock edge performs the final shift
// bcd    : packed BCD result, valid from the cycle after done
module bcd_converter #(
   parameter int BIN_W  = 14,
   parameter int DIGITS = 4
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                start,
   input  logic [BIN_W-1:0]    bin,
   output logic                done,
   output logic [4*DIGITS-1:0] bcd
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);

   logic [BIN_W-1:0] bin_q;
   logic [BCD_W-1:0] bcd_q;
   logic [BCD_W-1:0] bcd_next;
   logic [CNT_W-1:0] cnt_q;

   // Add-3 on every nibble >= 5, then shift left pulling in the next binary MSB.
   // The top nibble's carry bit is dropped: inputs are pre-clamped so it is
   // always zero.
   always_comb begin
      logic [3:0] nib;
      logic [3:0] adj;
      bcd_next    = '0;
      bcd_next[0] = bin_q[BIN_W-1];
      for (int i = 0; i < DIGITS; i++) begin
         nib = bcd_q[4*i +: 4];
         adj = (nib >= 4'd5) ? nib + 4'd3 : nib;
         bcd_next[4*i+1 +: 3] = adj[2:0];
         if (i < DIGITS - 1) begin
            bcd_next[4*i+4] = adj[3];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         bin_q <= '0;
         bcd_q <= '0;
         cnt_q <= '0;
      end else if (start) begin
         bin_q <= bin;
         bcd_q <= '0;
         cnt_q <= CNT_W'(BIN_W);
      end else if (cnt_q != '0) begin
         bin_q <= bin_q << 1;
         bcd_q <= bcd_next;
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   assign done = (cnt_q == CNT_W'(1));
   assign bcd  = bcd_q;

endmodule

// File: rtl/score_digit_scheduler.sv
// rtl/score_digit_scheduler.sv - score to BCD scheduler and digit ROM address generator
//
// i_clk, i_rst        : pixel clock, synchronous active-high reset
// xx, yy, aactive     : current pixel coordinates and visible-area flag
// i_score, i_score_load : new binary score and its one-cycle load strobe
// o_busy              : conversion, commit or pending load outstanding
// o_rom_addr          : digit ROM address for the current pixel (1 cycle latency)
// o_digit_on          : ROM data valid and to be drawn (2 cycle latency)
// o_bcd               : displayed BCD value
// Build option LEAD_ZERO_BLANK_EN : suppress leading zero digits.
module score_digit_scheduler
   import score_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int SCORE_W    = 14,
   parameter int X0         = 5,
   parameter int Y0         = 10,
   parameter int DIG_W      = 20,
   parameter int DIG_H      = 20,
   parameter int DIG_PITCH  = 25
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [9:0]              xx,
   input  logic [9:0]              yy,
   input  logic                    aactive,
   input  logic [SCORE_W-1:0]      i_score,
   input  logic                    i_score_load,
   output logic                    o_busy,
   output logic [ROM_AW-1:0]       o_rom_addr,
   output logic                    o_digit_on,
   output logic [4*NUM_DIGITS-1:0] o_bcd
);

   localparam int          BCD_W     = 4 * NUM_DIGITS;
   localparam logic [63:0] MAX_SCORE = score_clamp_max(NUM_DIGITS);

   sched_state_t       state_q, state_d;
   logic               pend_v;
   logic [SCORE_W-1:0] pend_val;
   logic [BCD_W-1:0]   disp_bcd;
   logic [SCORE_W-1:0] score_clamped;
   logic [SCORE_W-1:0] start_val;
   logic               conv_start;
   logic               conv_done;
   logic [BCD_W-1:0]   conv_bcd;
   logic               pend_take;
   logic               commit;
   logic               load_direct;
   logic [31:0]        xv, yv;
   logic               y_in;
   logic               out_band;

   assign xv = 32'(xx);
   assign yv = 32'(yy);

   assign y_in     = (yv >= 32'(Y0)) && (yv < 32'(Y0 + DIG_H));
   assign out_band = !y_in;

   always_comb begin
      if (64'(i_score) > MAX_SCORE) begin
         score_clamped = MAX_SCORE[SCORE_W-1:0];
      end else begin
         score_clamped = i_score;
      end
   end

   // ---------------- conversion scheduler ----------------

   // A load goes straight to the converter only when nothing else is queued;
   // otherwise it lands in (or overwrites) the one-deep pending slot.
   assign load_direct = (state_q == IDLE) && !pend_v;

   always_comb begin
      state_d    = state_q;
      conv_start = 1'b0;
      start_val  = score_clamped;
      pend_take  = 1'b0;
      commit     = 1'b0;
      case (state_q)
         IDLE: begin
            if (pend_v) begin
               conv_start = 1'b1;
               start_val  = pend_val;
               pend_take  = 1'b1;
               state_d    = CONVERT;
            end else if (i_score_load) begin
               conv_start = 1'b1;
               state_d    = CONVERT;
            end
         end
         CONVERT: begin
            if (conv_done) begin
               state_d = WAIT_COMMIT;
            end
         end
         WAIT_COMMIT: begin
            // Only update the display register while the beam is outside the
            // digit band so no frame shows a half-old, half-new score.
            if (out_band) begin
               commit = 1'b1;
               if (pend_v) begin
                  conv_start = 1'b1;
                  start_val  = pend_val;
                  pend_take  = 1'b1;
                  state_d    = CONVERT;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= IDLE;
         pend_v   <= 1'b0;
         pend_val <= '0;
         disp_bcd <= '0;
      end else begin
         state_q <= state_d;
         // A new load wins over consuming the slot in the same cycle.
         if (i_score_load && !load_direct) begin
            pend_v   <= 1'b1;
            pend_val <= score_clamped;
         end else if (pend_take) begin
            pend_v <= 1'b0;
         end
         if (commit) begin
            disp_bcd <= conv_bcd;
         end
      end
   end

   assign o_busy = (state_q != IDLE) || pend_v;
   assign o_bcd  = disp_bcd;

   bcd_converter #(
      .BIN_W  (SCORE_W),
      .DIGITS (NUM_DIGITS)
   ) u_bcd (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .start (conv_start),
      .bin   (start_val),
      .done  (conv_done),
      .bcd   (conv_bcd)
   );

   // ---------------- pixel pipeline ----------------

   logic              box_hit;
   logic              blank;
   logic [3:0]        glyph;
   logic [31:0]       xoff;
   logic [31:0]       yoff;
   logic [ROM_AW-1:0] addr_calc;
   logic              on_s1;

   // Box membership is decided on the raw coordinates first; offsets are only
   // formed for the selected box, so the subtractions can never underflow.
   always_comb begin
      logic hit_x;
`ifdef LEAD_ZERO_BLANK_EN
      logic zero_run;
      zero_run = 1'b1;
`endif
      hit_x = 1'b0;
      glyph = 4'd0;
      xoff  = '0;
      blank = 1'b0;
      for (int d = 0; d < NUM_DIGITS; d++) begin
`ifdef LEAD_ZERO_BLANK_EN
         zero_run = zero_run && (disp_bcd[4*(NUM_DIGITS-1-d) +: 4] == 4'd0);
`endif
         if (!hit_x && (xv >= 32'(X0 + d*DIG_PITCH)) &&
             (xv < 32'(X0 + d*DIG_PITCH + DIG_W))) begin
            hit_x = 1'b1;
            glyph = disp_bcd[4*(NUM_DIGITS-1-d) +: 4];
            xoff  = xv - 32'(X0 + d*DIG_PITCH);
`ifdef LEAD_ZERO_BLANK_EN
            // Rightmost digit is never blanked so a zero score still shows "0".
            blank = zero_run && (d < NUM_DIGITS - 1);
`endif
         end
      end
      yoff      = y_in ? (yv - 32'(Y0)) : 32'd0;
      box_hit   = aactive && y_in && hit_x;
      addr_calc = ROM_AW'(32'(glyph) * 32'(GLYPH_SIZE) + yoff * 32'(DIG_W) + xoff);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_rom_addr <= '0;
         on_s1      <= 1'b0;
         o_digit_on <= 1'b0;
      end else begin
         if (box_hit) begin
            o_rom_addr <= addr_calc;
         end
         on_s1      <= box_hit && !blank;
         // Extra stage lines the flag up with the ROM's registered read data.
         o_digit_on <= on_s1;
      end
   end

endmodule

// File: tb/tb_score_digit_scheduler.sv
// tb/tb_score_digit_scheduler.sv - self-checking bench for score_digit_scheduler
module tb_score_digit_scheduler;

   localparam int N  = 4;
   localparam int SW = 14;
   localparam int X0 = 5;
   localparam int Y0 = 10;
   localparam int DW = 20;
   localparam int DH = 20;
   localparam int DP = 25;

   logic          i_clk = 1'b0;
   logic          i_rst;
   logic [9:0]    xx, yy;
   logic          aactive;
   logic [SW-1:0] i_score;
   logic          i_score_load;
   logic          o_busy;
   logic [11:0]   o_rom_addr;
   logic          o_digit_on;
   logic [15:0]   o_bcd;

   always #5 i_clk = ~i_clk;

   score_digit_scheduler #(
      .NUM_DIGITS (N), .SCORE_W (SW), .X0 (X0), .Y0 (Y0),
      .DIG_W (DW), .DIG_H (DH), .DIG_PITCH (DP)
   ) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .xx           (xx),
      .yy           (yy),
      .aactive      (aactive),
      .i_score      (i_score),
      .i_score_load (i_score_load),
      .o_busy       (o_busy),
      .o_rom_addr   (o_rom_addr),
      .o_digit_on   (o_digit_on),
      .o_bcd        (o_bcd)
   );

   int checks   = 0;
   int failures = 0;
   int cyc_n    = 0;
   int m_score  = 0;
   int m_addr   = 0;

   always @(posedge i_clk) cyc_n <= cyc_n + 1;

   typedef struct {
      int x;
      int y;
      int a;
      int addr;
      int on;
   } vec_t;

   vec_t tbl[13];

   function automatic int pow10(input int e);
      int r = 1;
      for (int i = 0; i < e; i++) r = r * 10;
      return r;
   endfunction

   function automatic int clamp_score(input int s);
      return (s > pow10(N) - 1) ? pow10(N) - 1 : s;
   endfunction

   function automatic int to_bcd(input int s);
      int c = clamp_score(s);
      int r = 0;
      for (int d = 0; d < N; d++) r = r + (((c / pow10(d)) % 10) << (4 * d));
      return r;
   endfunction

   // Reference pixel model: which digit box (if any), its glyph and address.
   task automatic model_pix(input int x, input int y, input int a,
                            output int hit, output int vis, output int addr);
      int d, col;
      hit = 0; vis = 0; addr = 0;
      if (a != 0 && x >= X0 && y >= Y0 && y < Y0 + DH) begin
         d   = (x - X0) / DP;
         col = (x - X0) % DP;
         if (d < N && col < DW) begin
            hit  = 1;
            vis  = 1;
            addr = ((m_score / pow10(N - 1 - d)) % 10) * 400 + (y - Y0) * DW + col;
`ifdef LEAD_ZERO_BLANK_EN
            if (d < N - 1 && m_score < pow10(N - 1 - d)) vis = 0;
`endif
         end
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic cyc();
      @(posedge i_clk);
      @(negedge i_clk);
   endtask

   task automatic set_pix(input int x, input int y, input int a);
      xx      = 10'(x);
      yy      = 10'(y);
      aactive = (a != 0);
   endtask

   task automatic load(input int s);
      i_score      = SW'(s);
      i_score_load = 1'b1;
      cyc();
      i_score_load = 1'b0;
   endtask

   task automatic wait_idle(input int t0, output int dur);
      int k = 0;
      while (o_busy && k < 500) begin
         cyc();
         k++;
      end
      if (o_busy) chk("idle_timeout", 1, 0);
      dur = cyc_n - t0;
   endtask

   task automatic load_commit(input int s);
      int t0, dur;
      set_pix(0, 0, 0);
      load(s);
      t0 = cyc_n;
      wait_idle(t0, dur);
      m_score = clamp_score(s);
      chk("load_busy_cycles", dur, 15);
      chk("load_bcd", int'(o_bcd), to_bcd(s));
   endtask

   // mode 0: random pixels; mode 1: sweep row y=15 left to right.
   task automatic pix_run(input int n, input int mode);
      int hit, vis, addr, pv, x, y, a;
      set_pix(X0, Y0, 1);
      cyc();
      model_pix(X0, Y0, 1, hit, vis, addr);
      m_addr = addr;
      pv     = vis;
      chk("pix_sync_addr", int'(o_rom_addr), m_addr);
      for (int i = 0; i < n; i++) begin
         if (mode == 0) begin
            x = int'($urandom_range(0, 127));
            y = int'($urandom_range(0, 40));
            a = int'($urandom_range(0, 7) != 0);
         end else begin
            x = i; y = 15; a = 1;
         end
         set_pix(x, y, a);
         cyc();
         model_pix(x, y, a, hit, vis, addr);
         if (hit != 0) m_addr = addr;
         chk("pix_addr", int'(o_rom_addr), m_addr);
         chk("pix_on", int'(o_digit_on), pv);
         pv = vis;
      end
      set_pix(0, 0, 0);
      cyc();
      chk("pix_on_tail", int'(o_digit_on), pv);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

   initial begin
      int t0, dur;

      tbl[0]  = '{5,   10, 1, 400,  1};
      tbl[1]  = '{31,  11, 1, 821,  1};
      tbl[2]  = '{26,  11, 1, 821,  0};
      tbl[3]  = '{24,  29, 1, 799,  1};
      tbl[4]  = '{80,  10, 1, 1600, 1};
      tbl[5]  = '{99,  29, 1, 1999, 1};
      tbl[6]  = '{100, 10, 1, 1999, 0};
      tbl[7]  = '{55,  15, 1, 1300, 1};
      tbl[8]  = '{60,  15, 0, 1300, 0};
      tbl[9]  = '{5,   9,  1, 1300, 0};
      tbl[10] = '{5,   30, 1, 1300, 0};
      tbl[11] = '{0,   10, 1, 1300, 0};
      tbl[12] = '{49,  10, 1, 819,  1};

      i_rst        = 1'b1;
      i_score      = '0;
      i_score_load = 1'b0;
      set_pix(0, 0, 0);
      repeat (3) cyc();
      chk("rst_busy", int'(o_busy), 0);
      chk("rst_bcd", int'(o_bcd), 0);
      chk("rst_addr", int'(o_rom_addr), 0);
      chk("rst_on", int'(o_digit_on), 0);
      i_rst = 1'b0;
      cyc();

      // Basic load and conversion timing
      load_commit(1234);
      chk("bcd_1234", int'(o_bcd), 16'h1234);

      // Pixel latency: address after one cycle, draw flag after two
      set_pix(5, 10, 1);
      cyc();
      chk("lat_addr_1", int'(o_rom_addr), 400);
      chk("lat_on_1", int'(o_digit_on), 0);
      set_pix(0, 0, 0);
      cyc();
      chk("lat_on_2", int'(o_digit_on), 1);
      chk("lat_addr_hold", int'(o_rom_addr), 400);

      // Table of fixed pixel vectors against score 1234
      foreach (tbl[i]) begin
         set_pix(tbl[i].x, tbl[i].y, tbl[i].a);
         cyc();
         chk($sformatf("tbl%0d_addr", i), int'(o_rom_addr), tbl[i].addr);
         set_pix(0, 0, 0);
         cyc();
         chk($sformatf("tbl%0d_on", i), int'(o_digit_on), tbl[i].on);
         chk($sformatf("tbl%0d_hold", i), int'(o_rom_addr), tbl[i].addr);
      end

      // Clamp
      load_commit(12000);
      chk("clamp_9999", int'(o_bcd), 16'h9999);

      // Load during CONVERT becomes pending and chains with no idle gap
      set_pix(0, 0, 0);
      load(7);
      t0 = cyc_n;
      cyc();
      load(42);
      wait_idle(t0, dur);
      chk("chain_busy_cycles", dur, 30);
      chk("chain_bcd", int'(o_bcd), 16'h0042);
      m_score = 42;

      // Commit deferred while beam is inside the digit band
      set_pix(0, 15, 0);
      load(99);
      repeat (30) cyc();
      chk("defer_busy", int'(o_busy), 1);
      chk("defer_bcd_old", int'(o_bcd), 16'h0042);
      set_pix(0, 30, 0);
      cyc();
      chk("defer_bcd_new", int'(o_bcd), 16'h0099);
      chk("defer_idle", int'(o_busy), 0);

      // Load in the very cycle of the commit becomes pending
      set_pix(0, 15, 0);
      load(5);
      repeat (20) cyc();
      set_pix(0, 0, 0);
      i_score      = SW'(6);
      i_score_load = 1'b1;
      cyc();
      i_score_load = 1'b0;
      chk("samecyc_bcd", int'(o_bcd), 16'h0005);
      chk("samecyc_busy", int'(o_busy), 1);
      wait_idle(cyc_n, dur);
      chk("samecyc_final", int'(o_bcd), 16'h0006);

      // Boundary and random scores
      load_commit(9999);
      load_commit(10000);
      load_commit(0);
      load_commit(16383);
      for (int i = 0; i < 8; i++) load_commit(int'($urandom_range(0, 16383)));

      // Pixel model comparisons
      pix_run(200, 0);
      load_commit(42);
      pix_run(110, 1);
      load_commit(0);
      pix_run(110, 1);
      load_commit(int'($urandom_range(0, 9999)));
      pix_run(200, 0);

      // Reset in the middle of a conversion
      set_pix(0, 0, 0);
      load(555);
      repeat (4) cyc();
      set_pix(5, 10, 1);
      cyc();
      i_rst = 1'b1;
      cyc();
      chk("midrst_busy", int'(o_busy), 0);
      chk("midrst_bcd", int'(o_bcd), 0);
      chk("midrst_on", int'(o_digit_on), 0);
      chk("midrst_addr", int'(o_rom_addr), 0);
      i_rst = 1'b0;
      set_pix(0, 0, 0);
      repeat (20) cyc();
      chk("postrst_busy", int'(o_busy), 0);
      chk("postrst_bcd", int'(o_bcd), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
